// File: rtl/instr_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_packer_pkg
// Brief  : Shared immediate-format codes, FSM encoding and immediate limits.
// Rev    : 1.0  initial release
// ============================================================================
package instr_packer_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -1048576;
  localparam int IMM_J_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// Module : imm_pack
// Brief  : Places an immediate into its RISC-V bit positions and checks range.
// Rev    : 1.0  initial release
// ============================================================================
import instr_packer_pkg::*;

module imm_pack (
  input  logic        i_lui,
  input  logic [1:0]  i_imm_src,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_ok
);

  logic [31:0] w_word;
  logic        w_ok;

  // Only immediate bits are produced here; register/funct fields are ORed in by the caller.
  always_comb begin
    w_word = '0;
    w_ok   = 1'b0;
    if (i_lui) begin
      w_word[31:12] = i_imm[31:12];
      w_ok          = (i_imm[11:0] == 12'd0);
    end else begin
      case (i_imm_src)
        IMM_I: begin
          w_word[31:20] = i_imm[11:0];
          w_ok          = in_range(i_imm, IMM_IS_MIN, IMM_IS_MAX);
        end
        IMM_S: begin
          w_word[31:25] = i_imm[11:5];
          w_word[11:7]  = i_imm[4:0];
          w_ok          = in_range(i_imm, IMM_IS_MIN, IMM_IS_MAX);
        end
        IMM_B: begin
          w_word[31]    = i_imm[12];
          w_word[30:25] = i_imm[10:5];
          w_word[11:8]  = i_imm[4:1];
          w_word[7]     = i_imm[11];
          w_ok          = in_range(i_imm, IMM_B_MIN, IMM_B_MAX) && !i_imm[0];
        end
        default: begin
          w_word[31]    = i_imm[20];
          w_word[30:21] = i_imm[10:1];
          w_word[20]    = i_imm[11];
          w_word[19:12] = i_imm[19:12];
          w_ok          = in_range(i_imm, IMM_J_MIN, IMM_J_MAX) && !i_imm[0];
        end
      endcase
    end
  end

  assign o_word = w_word;
  assign o_ok   = w_ok;

endmodule
`default_nettype wire

// File: rtl/instr_packer.sv
`default_nettype none
// ============================================================================
// Module : instr_packer
// Brief  : Packs instruction fields into RISC-V words and writes them to memory.
// Rev    : 1.0  initial release
// ============================================================================
import instr_packer_pkg::*;

module instr_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lui_op,
  input  logic [1:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        clear_err
);

  state_t      r_state;
  logic        r_in_ready;
  logic        r_lui;
  logic [1:0]  r_imm_src;
  logic [6:0]  r_opcode;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_funct3;
  logic [31:0] r_imm;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_err_addr;

  logic [31:0] w_imm_word;
  logic        w_ok;
  logic [31:0] w_fields;
  logic        w_unused;

  // No supported format carries funct7.
  assign w_unused = ^funct7;

  imm_pack u_imm_pack (
    .i_lui     (r_lui),
    .i_imm_src (r_imm_src),
    .i_imm     (r_imm),
    .o_word    (w_imm_word),
    .o_ok      (w_ok)
  );

  always_comb begin
    w_fields = {25'd0, r_opcode};
    if (r_lui || (r_imm_src == IMM_J)) begin
      w_fields[11:7] = r_rd;
    end else if (r_imm_src == IMM_I) begin
      w_fields[11:7]  = r_rd;
      w_fields[14:12] = r_funct3;
      w_fields[19:15] = r_rs1;
    end else begin
      w_fields[14:12] = r_funct3;
      w_fields[19:15] = r_rs1;
      w_fields[24:20] = r_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_lui      <= 1'b0;
      r_imm_src  <= IMM_I;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_funct3   <= '0;
      r_imm      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // start wins over a simultaneous request, which is then left pending.
          if (start) begin
            r_addr <= base_addr;
          end else if (in_valid) begin
            r_lui      <= lui_op;
            r_imm_src  <= imm_src;
            r_opcode   <= opcode;
            r_rd       <= rd;
            r_rs1      <= rs1;
            r_rs2      <= rs2;
            r_funct3   <= funct3;
            r_imm      <= imm;
            r_in_ready <= 1'b0;
            r_state    <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (w_ok) begin
            r_wdata <= w_imm_word | w_fields;
            r_we    <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
            r_state    <= ST_ERR;
          end
        end
        ST_WRITE: begin
          r_addr     <= r_addr + 32'd4;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_ERR: begin
          if (clear_err) begin
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;
  assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_packer
// Brief  : Scoreboard bench for instr_packer write stream, errors and reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, lui_op, mem_we, err, clear_err;
  logic [31:0] base_addr, imm, mem_addr, mem_wdata, err_addr;
  logic [1:0]  imm_src;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] tb_addr = 32'd0;

  instr_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .lui_op(lui_op), .imm_src(imm_src),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err), .err_addr(err_addr), .clear_err(clear_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      exp_t e;
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] ref_pack(input logic lui, input logic [1:0] src,
      input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] v);
    if (lui) return {v[31:12], d, op};
    case (src)
      2'b00:   return {v[11:0], s1, f3, d, op};
      2'b01:   return {v[11:5], s2, s1, f3, v[4:0], op};
      2'b10:   return {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      default: return {v[20], v[10:1], v[11], v[19:12], d, op};
    endcase
  endfunction

  task automatic send(input logic lui, input logic [1:0] src, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [31:0] v, input logic exp_ok,
      input logic [31:0] exp_word);
    int   n;
    exp_t e;
    lui_op = lui; imm_src = src; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; imm = v; funct7 = 7'h7F; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 50);
    if (in_ready !== 1'b1) begin
      checks++; fails++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    if (exp_ok) begin
      e.addr = tb_addr; e.data = exp_word;
      exp_q.push_back(e);
      tb_addr = tb_addr + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tb_addr = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, mem_we, err} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags ready/we/err=%b required=100", {in_ready, mem_we, err});
    end
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || err_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_values addr=%h wdata=%h err_addr=%h required all 0",
               mem_addr, mem_wdata, err_addr);
    end
  endtask

  task automatic load_base(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    tb_addr = b;
    checks++;
    if (mem_addr !== b) begin
      fails++;
      $display("FAIL start_load addr=%h required=%h", mem_addr, b);
    end
  endtask

  task automatic test_i_latency();
    load_base(32'h100);
    send(1'b0, 2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 32'h00500093);
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL i_cycle_n1 we=%b ready=%b required we=0 ready=0", mem_we, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL i_latency we=%b required=1", mem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h104 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL i_after_write we=%b addr=%h ready=%b required we=0 addr=00000104 ready=1",
               mem_we, mem_addr, in_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    wr_cyc_q.delete();
    send(1'b0, 2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1'b1, 32'h0020A423);
    send(1'b0, 2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE000EE3);
    send(1'b0, 2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1, 32'h001000EF);
    drain();
    checks++;
    if (wr_cyc_q.size() != 3 || wr_cyc_q[1] - wr_cyc_q[0] != 3 || wr_cyc_q[2] - wr_cyc_q[1] != 3) begin
      fails++;
      $display("FAIL b2b_throughput writes=%0d required 3 writes spaced by 3 cycles", wr_cyc_q.size());
    end
    checks++;
    if (mem_addr !== 32'h110) begin
      fails++;
      $display("FAIL b2b_addr addr=%h required=00000110", mem_addr);
    end
  endtask

  task automatic test_lui();
    send(1'b1, 2'b10, 7'h37, 5'd5, 5'd3, 5'd4, 3'd7, 32'h12345000, 1'b1, 32'h123452B7);
    drain();
  endtask

  task automatic test_error(input logic [1:0] src, input logic [6:0] op, input logic [31:0] v);
    send(1'b0, src, op, 5'd1, 5'd2, 5'd3, 3'd0, v, 1'b0, 32'd0);
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b0 || err !== 1'b1 || err_addr !== tb_addr) begin
      fails++;
      $display("FAIL err_flag imm=%h we=%b err=%b err_addr=%h required we=0 err=1 err_addr=%h",
               v, mem_we, err, err_addr, tb_addr);
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL err_sticky err=%b ready=%b required err=1 ready=0", err, in_ready);
    end
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || mem_addr !== tb_addr) begin
      fails++;
      $display("FAIL err_clear err=%b ready=%b addr=%h required err=0 ready=1 addr=%h",
               err, in_ready, mem_addr, tb_addr);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] v;
    v = 32'd2047;
    send(1'b0, 2'b00, 7'h13, 5'd7, 5'd8, 5'd0, 3'd4, v, 1'b1, ref_pack(1'b0, 2'b00, 7'h13, 5'd7, 5'd8, 5'd0, 3'd4, v));
    v = 32'hFFFF_F800;
    send(1'b0, 2'b01, 7'h23, 5'd0, 5'd9, 5'd10, 3'd1, v, 1'b1, ref_pack(1'b0, 2'b01, 7'h23, 5'd0, 5'd9, 5'd10, 3'd1, v));
    v = 32'd4094;
    send(1'b0, 2'b10, 7'h63, 5'd0, 5'd11, 5'd12, 3'd5, v, 1'b1, ref_pack(1'b0, 2'b10, 7'h63, 5'd0, 5'd11, 5'd12, 3'd5, v));
    v = 32'hFFF0_0000;
    send(1'b0, 2'b11, 7'h6F, 5'd31, 5'd0, 5'd0, 3'd0, v, 1'b1, ref_pack(1'b0, 2'b11, 7'h6F, 5'd31, 5'd0, 5'd0, 3'd0, v));
    drain();
    test_error(2'b11, 7'h6F, 32'h0010_0000);
    test_error(2'b00, 7'h13, 32'hFFFF_F7FF);
  endtask

  task automatic test_start_priority();
    @(negedge clk);
    start = 1'b1; base_addr = 32'h200; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    tb_addr = 32'h200;
    checks++;
    if (in_ready !== 1'b1 || mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL start_priority ready=%b addr=%h required ready=1 addr=00000200", in_ready, mem_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_no_accept we=%b ready=%b required we=0 ready=1", mem_we, in_ready);
    end
  endtask

  task automatic test_reset_in_pack();
    send(1'b0, 2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_addr = 32'd0;
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_in_pack we=%b ready=%b addr=%h required we=0 ready=1 addr=0",
               mem_we, in_ready, mem_addr);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_wrap();
    load_base(32'hFFFF_FFFC);
    send(1'b0, 2'b00, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd100, 1'b1,
         ref_pack(1'b0, 2'b00, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd100));
    drain();
    checks++;
    if (mem_addr !== 32'd0) begin
      fails++;
      $display("FAIL addr_wrap addr=%h required=00000000", mem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; lui_op = 1'b0;
    imm_src = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0;
    funct7 = '0; imm = '0; clear_err = 1'b0;
    test_reset();
    test_i_latency();
    test_back_to_back();
    test_lui();
    test_error(2'b00, 7'h13, 32'd2048);
    test_error(2'b10, 7'h63, 32'd3);
    test_boundaries();
    test_start_priority();
    test_reset_in_pack();
    test_wrap();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
